i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_pkg.sv | 6 +
 rtl/i2c_in_filter.sv | 40 ++++
 rtl/i2c_slave_rx.sv | 111 +++++++++++
 tb/tb_i2c_slave_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C slave receiver (state encoding, bit-counter width, ACK level)
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
    localparam int CNT_W = 3;
    localparam logic ACK_LVL = 1'b0;
endpackage

// File: rtl/i2c_in_filter.sv
// i2c_in_filter: 2-flop synchroniser for one bus line plus optional glitch filter (I2C_GLITCH_FILTER_EN)
// Ports: clk, rst_n (async active-low), line_i (raw line level), line_o (synchronised, optionally filtered level).
// With I2C_GLITCH_FILTER_EN defined the output only follows FILT_LEN (>= 2) consecutive equal samples.
module i2c_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);
`ifdef I2C_GLITCH_FILTER_EN
    localparam int FL = FILT_LEN;
`else
    localparam int FL = FILT_LEN * 0;
`endif
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], line_i};
    end
    if (FL > 1) begin : g_filt
        logic [FL-2:0] hist_q;
        logic [FL-1:0] win;
        logic out_q;
        assign win = {hist_q, sync_q[1]};
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist_q <= '1;
                out_q  <= 1'b1;
            end else begin
                hist_q <= win[FL-2:0];
                out_q  <= &win ? 1'b1 : ~|win ? 1'b0 : out_q;
            end
        end
        assign line_o = out_q;
    end else begin : g_bypass
        assign line_o = sync_q[1];
    end
endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave receiver; ACKs its address and every data byte, strobes received bytes
// Ports: clk, rst_n (async active-low), scl_in/sda_in (bus levels), sda_oe (1 = pull SDA low),
// data_out (last byte), data_valid (1-clk strobe), busy (not IDLE), addr_hit (address ACKed, until STOP).
// Optional macro I2C_GLITCH_FILTER_EN enables the input glitch filters.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       addr_hit
);
    logic scl_s, sda_s, scl_p_q, sda_p_q;
    logic start, stop, rise, fall, last;
    state_t state_q;
    logic [7:0] shift_q, shift_d, data_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic done_q, sda_oe_q, data_valid_q, busy_q, addr_hit_q;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (.clk(clk), .rst_n(rst_n), .line_i(scl_in), .line_o(scl_s));
    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (.clk(clk), .rst_n(rst_n), .line_i(sda_in), .line_o(sda_s));

    // SCL must be high in both samples so an SDA change next to an SCL edge is not taken as START/STOP
    assign start   = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop    = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign rise    = scl_s & ~scl_p_q;
    assign fall    = ~scl_s & scl_p_q;
    assign last    = &cnt_q;
    assign shift_d = {shift_q[6:0], sda_s};

    // done_q marks that the 8th bit was sampled and the ACK decision waits for the next SCL fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_hit_q   <= 1'b0;
        end else begin
            scl_p_q      <= scl_s;
            sda_p_q      <= sda_s;
            data_valid_q <= 1'b0;
            if (start) begin
                state_q  <= ADDR;
                cnt_q    <= '0;
                done_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b1;
            end else if (stop) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                done_q     <= 1'b0;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                addr_hit_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, DATA: begin
                        if (rise && !done_q) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + 1'b1;
                            if (last) begin
                                done_q <= 1'b1;
                                if (state_q == DATA) begin
                                    data_out_q   <= shift_d;
                                    data_valid_q <= 1'b1;
                                end
                            end
                        end else if (fall && done_q) begin
                            done_q <= 1'b0;
                            if (state_q == DATA || (shift_q[7:1] == SLAVE_ADDR && !shift_q[0])) begin
                                state_q  <= (state_q == DATA) ? DATA_ACK : ADDR_ACK;
                                sda_oe_q <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (fall) begin
                            sda_oe_q   <= 1'b0;
                            addr_hit_q <= 1'b1;
                            state_q    <= DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign addr_hit   = addr_hit_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: directed I2C master stimulus with a data-byte scoreboard for i2c_slave_rx
module tb_i2c_slave_rx;
    import i2c_pkg::*;
    localparam int Q = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_in, sda_oe, data_valid, busy, addr_hit;
    logic [7:0] data_out;
    logic ack;
    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int oe_cnt = 0;
    int dv0, oe0;
    logic [7:0] exp_q[$];

    assign sda_in = sda_oe ? ACK_LVL : sda_m;
    always #5 clk = ~clk;

    i2c_slave_rx dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .addr_hit(addr_hit)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (data_valid) begin
            dv_cnt++;
            if (exp_q.size() == 0) chk("dv_unexpected", data_valid, 1'b0);
            else chk("sb_data_out", data_out, exp_q.pop_front());
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask
    task automatic i2c_start();
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
    endtask
    task automatic i2c_stop();
        sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
    endtask
    task automatic send_bit(input logic b);
        sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
    endtask
    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); a = sda_in; wq(); scl_m = 1'b0; wq();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr_hit", addr_hit, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        rst_n = 1'b1;
        wq();
        // valid write of 0xA5 to 0x50
        dv0 = dv_cnt;
        i2c_start();
        chk("a_busy", busy, 1'b1);
        send_byte(8'hA0, ack);
        chk("a_addr_ack", ack, 1'b0);
        chk("a_addr_hit", addr_hit, 1'b1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        chk("a_data_ack", ack, 1'b0);
        chk("a_data_out", data_out, 8'hA5);
        chk("a_addr_hit_hold", addr_hit, 1'b1);
        i2c_stop();
        chk("a_addr_hit_stop", addr_hit, 1'b0);
        chk("a_busy_stop", busy, 1'b0);
        chk("a_dv_count", 8'(dv_cnt - dv0), 8'd1);
        // wrong address 0x51
        dv0 = dv_cnt; oe0 = oe_cnt;
        i2c_start();
        send_byte(8'hA2, ack);
        chk("b_addr_nack", ack, 1'b1);
        send_byte(8'h3C, ack);
        chk("b_data_nack", ack, 1'b1);
        chk("b_state", 8'(dut.state_q), 8'(IGNORE));
        chk("b_addr_hit", addr_hit, 1'b0);
        i2c_stop();
        chk("b_state_stop", 8'(dut.state_q), 8'(IDLE));
        chk("b_oe_count", 8'(oe_cnt - oe0), 8'd0);
        chk("b_dv_count", 8'(dv_cnt - dv0), 8'd0);
        // read request to own address is not acknowledged
        dv0 = dv_cnt; oe0 = oe_cnt;
        i2c_start();
        send_byte(8'hA1, ack);
        chk("c_nack", ack, 1'b1);
        chk("c_busy", busy, 1'b1);
        chk("c_oe_count", 8'(oe_cnt - oe0), 8'd0);
        i2c_stop();
        chk("c_busy_stop", busy, 1'b0);
        chk("c_dv_count", 8'(dv_cnt - dv0), 8'd0);
        // partial byte discarded by repeated START
        dv0 = dv_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        chk("d_addr_ack1", ack, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        chk("d_state_rs", 8'(dut.state_q), 8'(ADDR));
        send_byte(8'hA0, ack);
        chk("d_addr_ack2", ack, 1'b0);
        exp_q.push_back(8'h11);
        send_byte(8'h11, ack);
        chk("d_data_ack", ack, 1'b0);
        chk("d_data_out", data_out, 8'h11);
        i2c_stop();
        chk("d_dv_count", 8'(dv_cnt - dv0), 8'd1);
        // reset during the data ACK slot
        i2c_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h77);
        for (int i = 7; i >= 0; i--) send_bit(1'((8'h77 >> i) & 1));
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
        chk("e_oe_before_rst", sda_oe, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("e_oe_rst", sda_oe, 1'b0);
        chk("e_busy_rst", busy, 1'b0);
        chk("e_addr_hit_rst", addr_hit, 1'b0);
        chk("e_dv_rst", data_valid, 1'b0);
        chk("e_data_out_rst", data_out, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        wq(); scl_m = 1'b0; wq();
        oe0 = oe_cnt;
        send_byte(8'hA0, ack);
        chk("e_no_ack_after_rst", ack, 1'b1);
        chk("e_busy_after_rst", busy, 1'b0);
        chk("e_oe_count", 8'(oe_cnt - oe0), 8'd0);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, ack);
        chk("e_ack_new_start", ack, 1'b0);
        i2c_stop();
`ifdef I2C_GLITCH_FILTER_EN
        wq();
        sda_m = 1'b0; @(negedge clk); sda_m = 1'b1;
        repeat (10) @(negedge clk);
        chk("g_busy", busy, 1'b0);
        chk("g_state", 8'(dut.state_q), 8'(IDLE));
`endif
        wq();
        chk("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
